// File: rtl/mbscore_alu_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mbscore_alu_arbiter_pkg
// Shared MBScore ALU constants: datapath width, opcode width and opcode
// encodings. ALU_OP_NOP is an encoding outside every defined operation. The
// ALU treats it as "hold the previous output", so it is what the ALU sees
// whenever no operation is being issued.
// ---------------------------------------------------------------------------
package mbscore_alu_arbiter_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int ALU_OP_WIDTH = 4;

    typedef logic [ALU_OP_WIDTH-1:0] alu_op_t;

    localparam alu_op_t ALU_OP_ADD = 4'd0;
    localparam alu_op_t ALU_OP_SUB = 4'd1;
    localparam alu_op_t ALU_OP_AND = 4'd2;
    localparam alu_op_t ALU_OP_OR  = 4'd3;
    localparam alu_op_t ALU_OP_XOR = 4'd4;
    localparam alu_op_t ALU_OP_SLL = 4'd5;
    localparam alu_op_t ALU_OP_SRL = 4'd6;

    // Must stay clear of every ALU_OP_* above.
    localparam alu_op_t ALU_OP_NOP = 4'hF;

endpackage

// File: rtl/mbscore_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mbscore_rr_arbiter
// Combinational round-robin grant. The search starts one position after
// last_i and wraps modulo N. The first requester it finds set wins.
//   req_i      N      request vector
//   last_i     IDX_W  index of the most recent grant
//   en_i       1      grant allowed this cycle; low forces gnt_o to zero
//   gnt_o      N      one-hot grant, or zero
//   gnt_idx_o  IDX_W  index of the granted requester (0 when none)
// ---------------------------------------------------------------------------
module mbscore_rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    input  logic             en_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o
);

    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        // NOTE: every variable written here gets a default before the loop.
        // A path that leaves one unassigned would infer a latch.
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IDX_W'((int'(last_i) + k) % N);
            if (en_i && !found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/mbscore_alu_arbiter.sv
// ---------------------------------------------------------------------------
// mbscore_alu_arbiter
// Shares one MBScore ALU among N_REQ requesters. One operation is in flight
// at a time: IDLE -> ISSUE (ALU samples on the falling edge) -> RESP (result
// is held until the owner accepts it). A new request can be accepted in the
// same RESP cycle that the response is taken.
//   clk, rst                 clock; asynchronous active-high reset
//   req_valid/req_ready      per-requester request handshake
//   req_a/req_b/req_op       packed per-requester operands and opcode
//   rsp_valid/rsp_ready      per-requester response handshake
//   rsp_data/rsp_cf          registered result and carry, shared by all
//   alu_in_a/b, alu_op_type  drive the ALU (NOP outside ISSUE)
//   alu_out, cf              ALU result and carry
//   busy                     high whenever not IDLE
// ---------------------------------------------------------------------------
module mbscore_alu_arbiter #(
    parameter int DATA_WIDTH   = mbscore_alu_arbiter_pkg::DATA_WIDTH,
    parameter int ALU_OP_WIDTH = mbscore_alu_arbiter_pkg::ALU_OP_WIDTH,
    parameter int N_REQ        = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_a,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_b,
    input  logic [N_REQ*ALU_OP_WIDTH-1:0] req_op,
    output logic [N_REQ-1:0]              rsp_valid,
    input  logic [N_REQ-1:0]              rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_cf,
    output logic [DATA_WIDTH-1:0]         alu_in_a,
    output logic [DATA_WIDTH-1:0]         alu_in_b,
    output logic [ALU_OP_WIDTH-1:0]       alu_op_type,
    input  logic [DATA_WIDTH-1:0]         alu_out,
    input  logic                          cf,
    output logic                          busy
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [ALU_OP_WIDTH-1:0] OP_NOP =
        ALU_OP_WIDTH'(mbscore_alu_arbiter_pkg::ALU_OP_NOP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP
    } state_e;

    state_e                  state_q;
    logic [IDX_W-1:0]        owner_q;
    logic [IDX_W-1:0]        last_grant_q;
    logic [DATA_WIDTH-1:0]   a_q;
    logic [DATA_WIDTH-1:0]   b_q;
    logic [ALU_OP_WIDTH-1:0] alu_op_q;
    logic [DATA_WIDTH-1:0]   rsp_data_q;
    logic                    rsp_cf_q;
    logic [N_REQ-1:0]        rsp_valid_q;

    logic                    rsp_hs;
    logic                    accept;
    logic                    req_hs;
    logic [N_REQ-1:0]        grant;
    logic [IDX_W-1:0]        grant_idx;
    logic [DATA_WIDTH-1:0]   sel_a;
    logic [DATA_WIDTH-1:0]   sel_b;
    logic [ALU_OP_WIDTH-1:0] sel_op;

    // Only the owner's rsp_ready matters; other bits are ignored.
    assign rsp_hs = (state_q == S_RESP) && rsp_ready[owner_q];
    // Accept window: IDLE, or the RESP cycle whose response is being taken.
    assign accept = !rst && ((state_q == S_IDLE) || rsp_hs);

    mbscore_rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i     (req_valid),
        .last_i    (last_grant_q),
        .en_i      (accept),
        .gnt_o     (grant),
        .gnt_idx_o (grant_idx)
    );

    assign req_ready = grant;
    assign req_hs    = |grant;

    assign sel_a  = req_a [int'(grant_idx)*DATA_WIDTH   +: DATA_WIDTH];
    assign sel_b  = req_b [int'(grant_idx)*DATA_WIDTH   +: DATA_WIDTH];
    assign sel_op = req_op[int'(grant_idx)*ALU_OP_WIDTH +: ALU_OP_WIDTH];

    // NOTE: the reset is asynchronous, so the ALU opcode drops to NOP as soon
    // as rst rises. It does not wait for the next clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= '0;
            last_grant_q <= IDX_W'(N_REQ - 1);
            a_q          <= '0;
            b_q          <= '0;
            alu_op_q     <= OP_NOP;
            rsp_data_q   <= '0;
            rsp_cf_q     <= 1'b0;
            rsp_valid_q  <= '0;
        end else begin
            case (state_q)
                S_ISSUE: begin
                    // The ALU sampled the issue registers on the falling edge.
                    // Its result is valid at this rising edge.
                    rsp_data_q  <= alu_out;
                    rsp_cf_q    <= cf;
                    rsp_valid_q <= N_REQ'(1) << owner_q;
                    alu_op_q    <= OP_NOP;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_hs) begin
                        rsp_valid_q <= '0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // NOTE: non-blocking assignments; the last one in the block wins.
            // An accept in IDLE or RESP overrides the state chosen above.
            if (req_hs) begin
                a_q          <= sel_a;
                b_q          <= sel_b;
                alu_op_q     <= sel_op;
                owner_q      <= grant_idx;
                last_grant_q <= grant_idx;
                state_q      <= S_ISSUE;
            end
        end
    end

    assign alu_in_a    = a_q;
    assign alu_in_b    = b_q;
    assign alu_op_type = alu_op_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_cf      = rsp_cf_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_mbscore_alu_arbiter.sv
module tb_mbscore_alu_arbiter;
    import mbscore_alu_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int OW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*DW-1:0] req_a, req_b;
    logic [N*OW-1:0] req_op;
    logic [DW-1:0]   rsp_data, alu_in_a, alu_in_b;
    logic            rsp_cf, busy;
    logic [OW-1:0]   alu_op_type;
    logic [DW-1:0]   alu_out = '0;
    logic            cf = 1'b0;

    logic          va[N];
    logic [DW-1:0] aa[N], ba[N];
    logic [OW-1:0] oa[N];
    logic [N-1:0]  rsp_rdy_r;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_valid[i]         = va[i];
            req_a[i*DW +: DW]    = aa[i];
            req_b[i*DW +: DW]    = ba[i];
            req_op[i*OW +: OW]   = oa[i];
        end
    end
    assign rsp_ready = rsp_rdy_r;

    mbscore_alu_arbiter #(.DATA_WIDTH(DW), .ALU_OP_WIDTH(OW), .N_REQ(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_cf(rsp_cf),
        .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_op_type(alu_op_type),
        .alu_out(alu_out), .cf(cf), .busy(busy)
    );

    // Golden ALU: {carry, result}. SUB carries the borrow. The shifts move b
    // by a[4:0] places.
    function automatic logic [DW:0] golden(input logic [OW-1:0] op,
                                           input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
        case (op)
            ALU_OP_ADD: return {1'b0, a} + {1'b0, b};
            ALU_OP_SUB: return {1'b0, a} - {1'b0, b};
            ALU_OP_AND: return {1'b0, a & b};
            ALU_OP_OR:  return {1'b0, a | b};
            ALU_OP_XOR: return {1'b0, a ^ b};
            ALU_OP_SLL: return {1'b0, b} << a[4:0];
            ALU_OP_SRL: return {1'b0, b >> a[4:0]};
            default:    return '0;
        endcase
    endfunction

    // ALU model: samples on the falling edge and holds its output for NOP.
    always @(negedge clk) begin
        if (alu_op_type !== ALU_OP_NOP)
            {cf, alu_out} <= golden(alu_op_type, alu_in_a, alu_in_b);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard: per-requester queues of posted operations, and the
    // operation in flight together with the cycle it was accepted in.
    // ------------------------------------------------------------------
    typedef struct {
        int            owner;
        logic [OW-1:0] op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] data;
        logic          c;
        int            acc;
    } txn_t;

    txn_t exp_q[N][$];
    txn_t fly_q[$];
    int   grant_log[$];

    int            cyc    = 0;
    int            last_m = N - 1;
    bit            m_have, m_rhs, m_allow;
    int            m_age, m_win, m_g;
    logic [OW-1:0] m_op;
    logic [N-1:0]  m_vld, m_rdy;
    txn_t          m_t;

    always @(negedge clk) begin : monitor
        cyc++;
        if (rst) begin
            check("rst_busy", busy, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_data", rsp_data, 0);
            check("rst_rsp_cf", rsp_cf, 0);
            check("rst_alu_op", alu_op_type, ALU_OP_NOP);
            check("rst_req_ready", req_ready, 0);
            fly_q.delete();
            last_m = N - 1;
        end else begin
            m_have = (fly_q.size() > 0);
            m_age  = m_have ? cyc - fly_q[0].acc : 0;
            m_op   = (m_have && m_age == 1) ? fly_q[0].op : ALU_OP_NOP;
            check("alu_op", alu_op_type, m_op);
            if (m_have && m_age == 1) begin
                check("alu_in_a", alu_in_a, fly_q[0].a);
                check("alu_in_b", alu_in_b, fly_q[0].b);
            end
            m_vld = (m_have && m_age >= 2) ? N'(1) << fly_q[0].owner : '0;
            check("rsp_valid", rsp_valid, m_vld);
            if (m_have && m_age >= 2) begin
                check("rsp_data", rsp_data, fly_q[0].data);
                check("rsp_cf", rsp_cf, fly_q[0].c);
            end
            check("busy", busy, m_have);
            m_rhs   = m_have && m_age >= 2 && rsp_ready[fly_q[0].owner];
            m_allow = !m_have || m_rhs;
            m_win   = m_allow ? rr_pick(req_valid, last_m) : -1;
            m_rdy   = (m_win >= 0) ? N'(1) << m_win : '0;
            check("req_ready", req_ready, m_rdy);
            if (req_ready != '0) begin
                m_g = -1;
                for (int i = 0; i < N; i++) if (req_ready[i]) m_g = i;
                grant_log.push_back(m_g);
            end
            if (m_rhs) void'(fly_q.pop_front());
            if (m_win >= 0) begin
                if (exp_q[m_win].size() > 0) begin
                    m_t     = exp_q[m_win].pop_front();
                    m_t.acc = cyc;
                    fly_q.push_back(m_t);
                end
                last_m = m_win;
            end
        end
    end

    // Called at posedge+1. Holds the request until it is accepted, then
    // releases it one edge later.
    task automatic post(input int idx, input logic [OW-1:0] op,
                        input logic [DW-1:0] a, input logic [DW-1:0] b);
        txn_t        t;
        logic [DW:0] r;
        int          n;
        r       = golden(op, a, b);
        t.owner = idx; t.op = op; t.a = a; t.b = b;
        t.data  = r[DW-1:0]; t.c = r[DW]; t.acc = 0;
        exp_q[idx].push_back(t);
        aa[idx] = a; ba[idx] = b; oa[idx] = op; va[idx] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[idx] && n < 200);
        check("req_accept", req_ready[idx], 1);
        if (!req_ready[idx]) void'(exp_q[idx].pop_back());
        @(posedge clk);
        #1;
        va[idx] = 1'b0;
    endtask

    task automatic run_rand(input int idx, input int n_ops);
        for (int i = 0; i < n_ops; i++)
            post(idx, OW'($urandom_range(0, 6)), $urandom, $urandom);
    endtask

    task automatic wait_rsp();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rsp_valid == '0 && n < 50);
        check("rsp_arrives", rsp_valid != '0, 1);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] d0;
    logic          c0;
    int            k;

    initial begin
        for (int i = 0; i < N; i++) begin
            va[i] = 1'b0; aa[i] = '0; ba[i] = '0; oa[i] = '0;
        end
        rsp_rdy_r = '1;
        #1 rst = 1'b1;
        repeat (3) sync();
        rst = 1'b0;
        sync();

        // Single ADD 5 + 7 from requester 0.
        post(0, ALU_OP_ADD, 32'd5, 32'd7);
        check("add_issue_op", alu_op_type, ALU_OP_ADD);
        check("add_issue_busy", busy, 1);
        wait_rsp();
        check("add_rsp_valid", rsp_valid, 4'b0001);
        check("add_rsp_data", rsp_data, 12);
        check("add_rsp_busy", busy, 1);
        sync();

        // SUB 0 - 1 and SLL a=4, b=1.
        post(0, ALU_OP_SUB, 32'd0, 32'd1);
        wait_rsp();
        check("sub_data", rsp_data, 32'hFFFF_FFFF);
        check("sub_cf", rsp_cf, 1);
        sync();
        post(0, ALU_OP_SLL, 32'd4, 32'd1);
        wait_rsp();
        check("sll_data", rsp_data, 16);
        sync();

        // Two requesters back to back with random operations.
        fork
            run_rand(0, 12);
            run_rand(1, 12);
        join
        repeat (4) sync();

        // Backpressure on requester 0 while requester 1 waits; a non-owner
        // rsp_ready bit is raised during the stall.
        rsp_rdy_r = '0;
        post(0, ALU_OP_ADD, $urandom, $urandom);
        fork
            post(1, ALU_OP_XOR, $urandom, $urandom);
        join_none
        wait_rsp();
        d0 = rsp_data;
        c0 = rsp_cf;
        sync();
        rsp_rdy_r = 4'b0010;
        sync();
        sync();
        check("bp_data_stable", rsp_data, d0);
        check("bp_cf_stable", rsp_cf, c0);
        check("bp_valid_held", rsp_valid, 4'b0001);
        check("bp_ready_blocked", req_ready, 0);
        k = grant_log.size();
        rsp_rdy_r = 4'b0011;
        wait fork;
        check("bp_release_grant_len", grant_log.size(), k + 1);
        if (grant_log.size() > k) check("bp_release_grant", grant_log[k], 1);
        rsp_rdy_r = '1;
        repeat (4) sync();

        // Reset in the middle of ISSUE.
        post(0, ALU_OP_ADD, $urandom, $urandom);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_alu_op", alu_op_type, ALU_OP_NOP);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_rsp_data", rsp_data, 0);
        check("mid_rst_alu_in_a", alu_in_a, 0);
        sync();
        sync();
        rst = 1'b0;
        sync();
        k = grant_log.size();
        fork
            post(0, ALU_OP_OR, $urandom, $urandom);
            post(3, ALU_OP_AND, $urandom, $urandom);
        join
        check("post_rst_log_len", grant_log.size() >= k + 2, 1);
        if (grant_log.size() >= k + 2) begin
            check("post_rst_first", grant_log[k], 0);
            check("post_rst_second", grant_log[k+1], 3);
        end

        // Requesters 1 and 3 only.
        k = grant_log.size();
        fork
            begin post(1, ALU_OP_ADD, $urandom, $urandom); post(1, ALU_OP_SRL, $urandom, $urandom); end
            begin post(3, ALU_OP_SUB, $urandom, $urandom); post(3, ALU_OP_SLL, $urandom, $urandom); end
        join
        check("rr13_log_len", grant_log.size() >= k + 4, 1);
        if (grant_log.size() >= k + 4) begin
            check("rr13_g0", grant_log[k],   1);
            check("rr13_g1", grant_log[k+1], 3);
            check("rr13_g2", grant_log[k+2], 1);
            check("rr13_g3", grant_log[k+3], 3);
        end

        repeat (6) sync();
        check("drain_fly", fly_q.size(), 0);
        for (int i = 0; i < N; i++) check("drain_exp", exp_q[i].size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
